// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs a request/ready handshake with
// instruction memory, and presents a registered instruction plus its PC to
// decode. Bubbles are all-zero words with instruction_valid low.
//
// A one-entry skid buffer catches the word returned by a handshake that
// completes while decode is stalled. The memory request therefore never has
// to be withdrawn mid-transfer.
//
// Optional feature: define FETCH_PERF_COUNTER_EN to add the fetch_count and
// bubble_count performance counter outputs.
//
// RESET_PC must be word aligned (low two bits zero).
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  imem_request,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_read_data,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instruction_pc,
  output logic                  instruction_valid
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           bubble_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // no request: after reset, or skid buffer full
    FETCH   = 2'd1,  // request outstanding, data goes to decode
    DISCARD = 2'd2   // request outstanding, data dropped after a branch
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   pend_target_q, pend_target_d;
  logic [31:0]             instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    valid_q, valid_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [31:0]             skid_data_q;
  logic [ADDR_WIDTH-1:0]   skid_pc_q;
  logic                    skid_load;
  logic                    handshake;
  logic [ADDR_WIDTH-1:0]   target_aligned;
  logic                    fetch_inc;
  logic                    bubble_inc;

  // The low target bits select a byte within the word and are ignored.
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  assign target_aligned = {branch_target[ADDR_WIDTH-1:2], 2'b00};
  assign imem_request   = (state_q != IDLE);
  assign imem_address   = pc_q;
  assign handshake      = imem_request & imem_ready;

  assign instruction       = instr_q;
  assign instruction_pc    = instr_pc_q;
  assign instruction_valid = valid_q;

  // Next-state, PC, output-register and skid-buffer decisions for one edge.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so paths that
    // do not mention a signal hold its value instead of inferring a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    valid_d       = valid_q;
    skid_valid_d  = skid_valid_q;
    skid_load     = 1'b0;
    fetch_inc     = 1'b0;
    bubble_inc    = 1'b0;

    if (branch_taken) begin
      // A redirect flushes everything visible to decode, even under stall.
      instr_d      = '0;
      instr_pc_d   = '0;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      bubble_inc   = ~stall;
      case (state_q)
        IDLE: begin
          pc_d    = target_aligned;
          state_d = FETCH;
        end
        FETCH, DISCARD: begin
          if (handshake) begin
            // The returned word belongs to the old path: drop it.
            pc_d    = target_aligned;
            state_d = FETCH;
          end else begin
            // Address must stay stable until memory accepts it, so the
            // target waits and the eventual data is discarded.
            pend_target_d = target_aligned;
            state_d       = DISCARD;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (skid_valid_q) begin
            if (!stall) begin
              instr_d      = skid_data_q;
              instr_pc_d   = skid_pc_q;
              valid_d      = 1'b1;
              skid_valid_d = 1'b0;
              state_d      = FETCH;
            end
          end else begin
            // Only reachable after reset: start fetching next edge.
            state_d = FETCH;
            if (!stall) begin
              instr_d    = '0;
              valid_d    = 1'b0;
              bubble_inc = 1'b1;
            end
          end
        end
        FETCH: begin
          if (handshake) begin
            fetch_inc = 1'b1;
            pc_d      = pc_q + PC_STEP;
            if (!stall) begin
              instr_d    = imem_read_data;
              instr_pc_d = pc_q;
              valid_d    = 1'b1;
            end else begin
              skid_load    = 1'b1;
              skid_valid_d = 1'b1;
              state_d      = IDLE;
            end
          end else if (!stall) begin
            instr_d    = '0;
            valid_d    = 1'b0;
            bubble_inc = 1'b1;
          end
        end
        DISCARD: begin
          if (handshake) begin
            pc_d    = pend_target_q;
            state_d = FETCH;
          end
          if (!stall) begin
            instr_d    = '0;
            valid_d    = 1'b0;
            bubble_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      valid_q       <= 1'b0;
      skid_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      valid_q       <= valid_d;
      skid_valid_q  <= skid_valid_d;
    end
  end

  // Skid buffer payload, captured when a handshake lands during stall.
  // NOTE: payload is not reset; skid_valid_q alone decides whether it is
  // ever used, so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_q <= imem_read_data;
      skid_pc_q   <= pc_q;
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count_q;
  logic [31:0] bubble_count_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      if (fetch_inc)  fetch_count_q  <= fetch_count_q + 32'd1;
      if (bubble_inc) bubble_count_q <= bubble_count_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  // Counter events exist in the datapath but have no consumer here.
  logic unused_perf_events;
  assign unused_perf_events = fetch_inc | bubble_inc;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end producer of the 32-bit instruction word consumed by the combinational control unit. Holds the PC and runs a request/ready handshake with instruction memory. Presents a registered instruction and its PC to decode, and inserts all-zero NOP bubbles on memory wait, branch flush and reset. Includes a one-entry skid buffer, so decode stall never breaks an in-flight memory handshake.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
RESET_PC, 0, PC after reset; must be word aligned (low 2 bits 0)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
stall  input  1  decode stage cannot accept a new instruction; hold outputs
branch_taken  input  1  redirect fetch; flush instruction in flight
branch_target  input  ADDR_WIDTH  redirect address; bits [1:0] ignored (forced 0)
imem_request  output  1  memory request valid
imem_address  output  ADDR_WIDTH  memory word address (= pc)
imem_ready  input  1  memory accepts request; imem_read_data valid this cycle
imem_read_data  input  32  instruction word from memory
instruction  output  32  registered instruction to control unit; 32'b0 = NOP
instruction_pc  output  ADDR_WIDTH  address of instruction
instruction_valid  output  1  instruction is real, not a bubble

Behaviour:
- Reset (async, immediate): state IDLE, pc=RESET_PC, imem_request=0, imem_address=RESET_PC, instruction=0, instruction_pc=0, instruction_valid=0, skid buffer empty, pending target cleared. Reset mid-transfer abandons the request; memory tolerates request drop.
- Handshake = imem_request & imem_ready at posedge. Once request is asserted without ready, request and address stay stable until handshake.
- imem_request = (state != IDLE); imem_address = pc (registered).
- Edge-event priority: reset > branch_taken > stall > normal.
- States:
  - IDLE:
    - request 0.
    - Entered on reset, and when the skid buffer fills.
    - Goes to FETCH when the buffer is empty, or on branch_taken.
    - First request is asserted the cycle after reset release.
  - FETCH: request 1.
    - Handshake, stall=0, no branch: instruction<=imem_read_data, instruction_pc<=pc, valid<=1, pc<=pc+4.
    - Handshake, stall=1: data and pc go to skid buffer, pc<=pc+4, go IDLE; outputs held.
    - No handshake, stall=0: instruction<=0, valid<=0 (bubble).
    - No handshake, stall=1: outputs held.
  - DISCARD:
    - request 1, address unchanged.
    - Handshake: drop data, pc<=pending target, go FETCH.
    - branch_taken during DISCARD overwrites pending target.
    - Outputs remain NOP/valid=0.
- branch_taken (overrides stall): instruction<=0, instruction_pc<=0, valid<=0, skid buffer cleared.
  - In FETCH with handshake same cycle: data dropped, pc<=target, stay FETCH.
  - In FETCH without handshake: pending target<=target, go DISCARD.
  - In IDLE: pc<=target, go FETCH.
- Stall release with skid buffer full: outputs<=buffer contents, valid<=1, buffer empty, IDLE->FETCH on the same edge.
- Latency: handshake at edge N -> instruction visible after edge N; back-to-back zero-wait memory gives 1 instruction/cycle.
- pc+4 wraps modulo 2^ADDR_WIDTH (e.g. 0xFFFFFFFC -> 0x00000000).
- Memory returning 32'b0 yields instruction=0 with valid=1; decode treats it as NOP.

Optional Feature:
FETCH_PERF_COUNTER_EN:
- Defined: adds outputs fetch_count[31:0] and bubble_count[31:0], both reset to 0.
  - fetch_count increments on each handshake whose data reaches the output or skid buffer.
  - bubble_count increments on each edge where valid is loaded 0 while stall=0.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; behaviour otherwise identical.

Test Plan:
- Reset release, imem_ready=1 constant, memory returns 0xE0810002 at 0x0 and 0xE2433001 at 0x4 -> request rises cycle 1; valid=1 with pc 0x0 then 0x4 on consecutive cycles; address steps 0x0,0x4,0x8.
- imem_ready low 3 cycles at 0x8 -> address stable 0x8, request held, instruction=0/valid=0 for 3 cycles, then data at pc 0x8.
- stall=1 for 4 cycles while ready=1 -> one extra word (0xC) captured in skid buffer, request drops, outputs frozen; on release 0xC word appears next edge, fetch resumes at 0x10.
- branch_taken with target 0x103 while request pending, ready=0 -> outputs flushed to NOP; old address held; on ready, data discarded; next address 0x100.
- branch_taken and stall both high with skid buffer full -> buffer cleared, valid=0, next request at target.
- reset_n low mid-wait at pc 0x20 -> request 0 and address RESET_PC immediately, no clock needed; restart from RESET_PC.
